// File: rtl/waveform_stats.sv
// Streaming per-frame average/min/max over SAMPLES unsigned samples, with a serial restoring divider.
// Optional build macro WAVEFORM_STATS_ROUND_EN: average rounds to nearest (ties up) instead of truncating.
module waveform_stats #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned SAMPLES = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] avg,
    output logic [DATA_W-1:0] min,
    output logic [DATA_W-1:0] max
);

    localparam int unsigned SUM_W     = DATA_W + $clog2(SAMPLES);
    localparam int unsigned CNT_W     = $clog2(SAMPLES);
    localparam int unsigned DIV_CNT_W = $clog2(SUM_W);
`ifdef WAVEFORM_STATS_ROUND_EN
    localparam int unsigned RND       = SAMPLES / 2;
`else
    localparam int unsigned RND       = 0;
`endif

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_DIV   = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic                   accept, last, div_done;
    logic [CNT_W-1:0]       cnt_q;
    logic [SUM_W-1:0]       sum_q, sum_acc, dividend;
    logic [DATA_W-1:0]      min_w, max_w;
    logic [DIV_CNT_W-1:0]   div_cnt_q;
    logic [SUM_W-1:0]       quo_q, quo_nx;
    logic [SUM_W-1:0]       rem_q;
    logic [SUM_W:0]         rem_sh, rem_nx;
    logic                   div_ge;

    // Next-state and per-cycle control decode
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        div_done  = 1'b0;
        case (state)
            S_ACCUM: begin
                accept = in_valid & ~clr;
                last   = accept & (cnt_q == CNT_W'(SAMPLES - 1));
                if (last) state_nxt = S_DIV;
            end
            S_DIV: begin
                div_done = ~clr & (div_cnt_q == DIV_CNT_W'(SUM_W - 1));
                if (div_done) state_nxt = S_ACCUM;
            end
            default: state_nxt = S_ACCUM;
        endcase
        if (clr) state_nxt = S_ACCUM;
    end

    // Running sum including the sample being accepted; rounding bias folded into the dividend
    always_comb begin
        sum_acc  = sum_q + SUM_W'(in_data);
        dividend = sum_acc + SUM_W'(RND);
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_sh = {rem_q, quo_q[SUM_W-1]};
        div_ge = (rem_sh >= (SUM_W+1)'(SAMPLES));
        rem_nx = div_ge ? (rem_sh - (SUM_W+1)'(SAMPLES)) : rem_sh;
        quo_nx = {quo_q[SUM_W-2:0], div_ge};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_ACCUM;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == S_ACCUM);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            sum_q     <= '0;
            min_w     <= '0;
            max_w     <= '0;
            div_cnt_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            out_valid <= 1'b0;
            avg       <= '0;
            min       <= '0;
            max       <= '0;
        end else if (clr) begin
            cnt_q     <= '0;
            sum_q     <= '0;
            min_w     <= '0;
            max_w     <= '0;
            div_cnt_q <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= div_done;
            if (accept) begin
                sum_q <= sum_acc;
                if (!last) cnt_q <= cnt_q + CNT_W'(1);
                // First sample of a frame seeds both extremes
                if (cnt_q == '0 || in_data < min_w) min_w <= in_data;
                if (cnt_q == '0 || in_data > max_w) max_w <= in_data;
                if (last) begin
                    quo_q     <= dividend;
                    rem_q     <= '0;
                    div_cnt_q <= '0;
                end
            end
            if (state == S_DIV) begin
                quo_q     <= quo_nx;
                rem_q     <= SUM_W'(rem_nx);
                div_cnt_q <= div_cnt_q + DIV_CNT_W'(1);
                if (div_done) begin
                    avg   <= DATA_W'(quo_nx);
                    min   <= min_w;
                    max   <= max_w;
                    cnt_q <= '0;
                    sum_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_waveform_stats.sv
// Self-checking bench for waveform_stats: directed frames, scoreboard of expected frame results.
module tb_waveform_stats;

    localparam int unsigned DATA_W  = 12;
    localparam int unsigned SAMPLES = 80;
    localparam int unsigned SUM_W   = DATA_W + $clog2(SAMPLES);
`ifdef WAVEFORM_STATS_ROUND_EN
    localparam int RND = SAMPLES / 2;
`else
    localparam int RND = 0;
`endif

    typedef struct {
        int avg;
        int mn;
        int mx;
    } res_t;

    logic              clk;
    logic              rst;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] avg;
    logic [DATA_W-1:0] min;
    logic [DATA_W-1:0] max;

    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;
    int   pushed   = 0;
    res_t sb[$];
    res_t last_res = '{0, 0, 0};
    int   smp[$];

    waveform_stats #(.DATA_W(DATA_W), .SAMPLES(SAMPLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .avg      (avg),
        .min      (min),
        .max      (max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every result pulse must match the oldest expected frame
    always @(posedge clk) begin
        #1;
        if (rst === 1'b1 && out_valid === 1'b1) begin
            res_t e;
            pulses++;
            chk("unexpected_pulse", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("avg", 32'(avg), 32'(e.avg));
                chk("min", 32'(min), 32'(e.mn));
                chk("max", 32'(max), 32'(e.mx));
                last_res = e;
            end
        end
    end

    function automatic res_t exp_of();
        res_t r;
        int   s = 0;
        r.mn = smp[0];
        r.mx = smp[0];
        foreach (smp[i]) begin
            s += smp[i];
            if (smp[i] < r.mn) r.mn = smp[i];
            if (smp[i] > r.mx) r.mx = smp[i];
        end
        r.avg = (s + RND) / int'(SAMPLES);
        return r;
    endfunction

    task automatic push_exp();
        sb.push_back(exp_of());
        pushed++;
    endtask

    // Offer one sample and hold it until an edge with in_ready high takes it
    task automatic send_sample(input int d, output int waits);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        waits    = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (in_ready === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
            waits++;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_all(input bit gap);
        int w;
        foreach (smp[i]) begin
            send_sample(smp[i], w);
            if (gap && i != smp.size() - 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Called right after the last sample's edge: measures latency and the ready-low window
    task automatic div_window(input string tag, input bit post);
        int lat = 0;
        int low = 0;
        if (in_ready === 1'b0) low++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
            if (in_ready === 1'b0) low++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(SUM_W));
        chk({tag, "_ready_low"}, 32'(low), 32'(SUM_W));
        chk({tag, "_ready_at_result"}, 32'(in_ready), 32'd1);
        if (post) begin
            @(posedge clk); #1;
            chk({tag, "_pulse_width"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        int w;
        int p0;
        rst      = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_avg", 32'(avg), 32'd0);
        chk("rst_min", 32'(min), 32'd0);
        chk("rst_max", 32'(max), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Ramp 0..79, continuous valid
        smp.delete();
        for (int i = 0; i < int'(SAMPLES); i++) smp.push_back(i);
        push_exp();
        send_all(1'b0);
        div_window("ramp", 1'b1);

        // Full scale
        smp.delete();
        for (int i = 0; i < int'(SAMPLES); i++) smp.push_back(4095);
        push_exp();
        send_all(1'b0);
        div_window("full", 1'b1);

        // Alternating 100/3000 with a gap between every sample
        smp.delete();
        for (int i = 0; i < int'(SAMPLES); i++) smp.push_back((i % 2 == 0) ? 100 : 3000);
        push_exp();
        send_all(1'b1);
        div_window("gapped", 1'b1);

        // Backpressure: distinct sample 7 offered throughout the division
        smp.delete();
        for (int i = 0; i < int'(SAMPLES); i++) smp.push_back(3 * i + 50);
        push_exp();
        send_all(1'b0);
        in_valid = 1'b1;
        in_data  = DATA_W'(7);
        div_window("bp", 1'b0);
        smp.delete();
        smp.push_back(7);
        for (int i = 1; i < int'(SAMPLES); i++) smp.push_back(1234);
        push_exp();
        send_sample(7, w);
        chk("bp_accept_edge", 32'(w), 32'd1);
        chk("bp_pulse_width", 32'(out_valid), 32'd0);
        void'(smp.pop_front());
        send_all(1'b0);
        smp.push_front(7);
        div_window("bp_next", 1'b1);

        // Abort after 40 samples; clr collides with a valid handshake
        for (int i = 0; i < 40; i++) send_sample(2000, w);
        in_data = DATA_W'(9);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_hold_avg", 32'(avg), 32'(last_res.avg));
        chk("clr_hold_min", 32'(min), 32'(last_res.mn));
        chk("clr_hold_max", 32'(max), 32'(last_res.mx));
        chk("clr_ready", 32'(in_ready), 32'd1);
        p0 = pulses;
        smp.delete();
        for (int i = 0; i < int'(SAMPLES); i++) smp.push_back(500);
        push_exp();
        for (int i = 0; i < 40; i++) send_sample(500, w);
        chk("clr_mid_hold_avg", 32'(avg), 32'(last_res.avg));
        chk("clr_mid_hold_min", 32'(min), 32'(last_res.mn));
        for (int i = 40; i < int'(SAMPLES); i++) send_sample(500, w);
        in_valid = 1'b0;
        div_window("clr_frame", 1'b1);
        chk("clr_one_pulse", 32'(pulses - p0), 32'd1);

        // Asynchronous reset in the middle of a division
        smp.delete();
        for (int i = 0; i < int'(SAMPLES); i++) smp.push_back(i + 900);
        push_exp();
        send_all(1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        void'(sb.pop_back());
        pushed--;
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_avg", 32'(avg), 32'd0);
        chk("arst_max", 32'(max), 32'd0);
        last_res = '{0, 0, 0};
        p0 = pulses;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("arst_no_pulse", 32'(pulses - p0), 32'd0);
        chk("arst_min_hold", 32'(min), 32'd0);

        // Random frame after reset recovery
        smp.delete();
        for (int i = 0; i < int'(SAMPLES); i++) smp.push_back(int'($urandom_range(200, 3900)));
        push_exp();
        send_all(1'b0);
        div_window("post_rst", 1'b1);

        repeat (2) @(posedge clk);
        #2;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("pulse_count", 32'(pulses), 32'(pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
